// File: rtl/div_fmt_pkg.sv
// Shared types and ASCII frame constants for the divider result formatter.
// The optional divide-by-zero message is enabled with DIV_FMT_DZ_MSG_EN.
package div_fmt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_Z  = 8'h5A;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] FRAME_LEN    = 3'd6;
    localparam logic [IDX_W-1:0] DZ_FRAME_LEN = 3'd3;

endpackage

// File: rtl/bin4_to_ascii2.sv
// Combinational 4-bit value to two ASCII decimal digits, leading zero kept.
module bin4_to_ascii2
    import div_fmt_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [7:0] o_tens,
    output logic [7:0] o_units
);

    logic       w_ge10;
    logic [3:0] w_units_bin;

    assign w_ge10      = (i_value >= 4'd10);
    assign w_units_bin = w_ge10 ? (i_value - 4'd10) : i_value;

    assign o_tens  = w_ge10 ? (CH_0 + 8'd1) : CH_0;
    assign o_units = CH_0 + {4'b0000, w_units_bin};

endmodule

// File: rtl/div_ascii_formatter.sv
// Serialises one divider result into an ASCII frame, one byte per handshake.
// DIV_FMT_DZ_MSG_EN replaces the frame with "DZ\n" when the divisor was zero.
module div_ascii_formatter
    import div_fmt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_quotient,
    input  logic [3:0] in_remainder,
    input  logic       in_dz,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_len;
    logic [3:0]       r_quot;
    logic [3:0]       r_rem;
    logic [7:0]       w_q_tens;
    logic [7:0]       w_q_units;
    logic [7:0]       w_r_tens;
    logic [7:0]       w_r_units;
    logic [7:0]       w_data;
    logic             w_capture;
    logic             w_advance;
    logic             w_is_last;

`ifdef DIV_FMT_DZ_MSG_EN
    logic r_dz;
    assign w_len = r_dz ? DZ_FRAME_LEN : FRAME_LEN;
`else
    logic w_dz_unused;
    assign w_dz_unused = in_dz;
    assign w_len       = FRAME_LEN;
`endif

    bin4_to_ascii2 u_quot_ascii (
        .i_value (r_quot),
        .o_tens  (w_q_tens),
        .o_units (w_q_units)
    );

    bin4_to_ascii2 u_rem_ascii (
        .i_value (r_rem),
        .o_tens  (w_r_tens),
        .o_units (w_r_units)
    );

    // in_ready is held low during reset so no capture can race the reset edge.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign w_capture = in_valid && in_ready;
    assign out_valid = (r_state == EMIT);
    assign busy      = out_valid;
    assign w_advance = out_valid && out_ready;
    assign w_is_last = (r_idx == (w_len - 3'd1));
    assign out_last  = out_valid && w_is_last;
    assign out_data  = w_data;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_next_state = EMIT;
            EMIT:    if (w_advance && w_is_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_data = 8'h00;
        if (out_valid) begin
            case (r_idx)
                3'd0:    w_data = w_q_tens;
                3'd1:    w_data = w_q_units;
                3'd2:    w_data = CH_R;
                3'd3:    w_data = w_r_tens;
                3'd4:    w_data = w_r_units;
                default: w_data = CH_LF;
            endcase
`ifdef DIV_FMT_DZ_MSG_EN
            if (r_dz) begin
                case (r_idx)
                    3'd0:    w_data = CH_D;
                    3'd1:    w_data = CH_Z;
                    default: w_data = CH_LF;
                endcase
            end
`endif
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef DIV_FMT_DZ_MSG_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_idx  <= '0;
                r_quot <= in_quotient;
                r_rem  <= in_remainder;
`ifdef DIV_FMT_DZ_MSG_EN
                r_dz   <= in_dz;
`endif
            end else if (w_advance) begin
                r_idx <= w_is_last ? '0 : (r_idx + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_div_ascii_formatter.sv
// Directed bench for div_ascii_formatter with a frame-level reference model.
module tb_div_ascii_formatter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_quotient;
    logic [3:0] in_remainder;
    logic       in_dz;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       rst_at_edge = 1'b0;
    logic       prev_stall  = 1'b0;
    logic [8:0] prev_out    = '0;

    localparam int LIMIT = 300;

    always #5 clk = ~clk;

    div_ascii_formatter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_quotient  (in_quotient),
        .in_remainder (in_remainder),
        .in_dz        (in_dz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame contents from decimal arithmetic on the captured result.
    function automatic void push_frame(input logic [3:0] q, input logic [3:0] r, input logic dz);
        int vq;
        int vr;
        vq = int'(q);
        vr = int'(r);
`ifdef DIV_FMT_DZ_MSG_EN
        if (dz) begin
            exp_q.push_back(8'h44);
            exp_q.push_back(8'h5A);
            exp_q.push_back(8'h0A);
            return;
        end
`else
        if (dz) begin end
`endif
        exp_q.push_back(8'(48 + vq / 10));
        exp_q.push_back(8'(48 + vq % 10));
        exp_q.push_back(8'h52);
        exp_q.push_back(8'(48 + vr / 10));
        exp_q.push_back(8'(48 + vr % 10));
        exp_q.push_back(8'h0A);
    endfunction

    always @(posedge clk) rst_at_edge <= rst_n;

    always @(negedge clk) begin
        if (!rst_at_edge) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_last", 32'(out_last), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'(rst_n));
            exp_q.delete();
            prev_stall = 1'b0;
            if (rst_n && in_valid) push_frame(in_quotient, in_remainder, in_dz);
        end else if (!rst_n) begin
            check("in_ready_in_reset", 32'(in_ready), 32'd0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            if (exp_q.size() != 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
                if (prev_stall) check("stall_hold", 32'({out_last, out_data}), 32'(prev_out));
                prev_stall = !out_ready;
                prev_out   = {out_last, out_data};
                if (out_ready) begin
                    got_q.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_out_data", 32'(out_data), 32'd0);
                check("idle_out_last", 32'(out_last), 32'd0);
                prev_stall = 1'b0;
                if (in_valid) push_frame(in_quotient, in_remainder, in_dz);
            end
        end
    end

    task automatic send(input logic [3:0] q, input logic [3:0] r, input logic dz);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid     = 1'b1;
        in_quotient  = q;
        in_remainder = r;
        in_dz        = dz;
        @(negedge clk);
        while (!in_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("send_bound", 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
        in_valid     = 1'b0;
        in_quotient  = 4'($urandom);
        in_remainder = 4'($urandom);
        in_dz        = 1'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("idle_bound", 32'(n < LIMIT), 32'd1);
    endtask

    task automatic expect_got(input string name, input logic [7:0] e[$]);
        check({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            check($sformatf("%s_b%0d", name, i), 32'(got_q[i]), 32'(e[i]));
        got_q.delete();
    endtask

    initial begin
        int n;
        logic [7:0] e[$];

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_quotient  = '0;
        in_remainder = '0;
        in_dz        = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_post_reset", 32'(in_ready), 32'd1);

        // 13 r 2 at full rate
        got_q.delete();
        send(4'd13, 4'd2, 1'b0);
        wait_idle(n);
        check("emit_cycles_13_2", 32'(n), 32'd6);
        e = '{8'h31, 8'h33, 8'h52, 8'h30, 8'h32, 8'h0A};
        expect_got("f13_2", e);

        send(4'd15, 4'd15, 1'b0);
        wait_idle(n);
        e = '{8'h31, 8'h35, 8'h52, 8'h31, 8'h35, 8'h0A};
        expect_got("f15_15", e);

        send(4'd0, 4'd0, 1'b0);
        wait_idle(n);
        e = '{8'h30, 8'h30, 8'h52, 8'h30, 8'h30, 8'h0A};
        expect_got("f0_0", e);

        // random back-pressure
        send(4'd9, 4'd3, 1'b0);
        n = 0;
        while (n < LIMIT) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) break;
            n++;
            @(posedge clk); #1;
        end
        check("bp_bound", 32'(n < LIMIT), 32'd1);
        out_ready = 1'b1;
        e = '{8'h30, 8'h39, 8'h52, 8'h30, 8'h33, 8'h0A};
        expect_got("f9_3_bp", e);

        // divide-by-zero
        send(4'd0, 4'd7, 1'b1);
        wait_idle(n);
`ifdef DIV_FMT_DZ_MSG_EN
        check("emit_cycles_dz", 32'(n), 32'd3);
        e = '{8'h44, 8'h5A, 8'h0A};
`else
        check("emit_cycles_dz", 32'(n), 32'd6);
        e = '{8'h30, 8'h30, 8'h52, 8'h30, 8'h37, 8'h0A};
`endif
        expect_got("fdz", e);

        // reset after byte 2 is accepted
        send(4'd4, 4'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_midreset", 32'(in_ready), 32'd1);
        e = '{8'h30, 8'h34, 8'h52};
        expect_got("fmidreset", e);
        send(4'd2, 4'd1, 1'b0);
        wait_idle(n);
        e = '{8'h30, 8'h32, 8'h52, 8'h30, 8'h31, 8'h0A};
        expect_got("f2_1_after_reset", e);

        // back-to-back in_valid with inputs changing every cycle
        @(posedge clk); #1;
        in_valid     = 1'b1;
        in_quotient  = 4'd10;
        in_remainder = 4'd11;
        in_dz        = 1'b0;
        @(negedge clk);
        check("b2b_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (j < 7) begin
                in_quotient  = 4'(j);
                in_remainder = 4'(15 - j);
            end else begin
                in_valid = 1'b0;
            end
        end
        wait_idle(n);
        e = '{8'h31, 8'h30, 8'h52, 8'h31, 8'h31, 8'h0A,
              8'h30, 8'h36, 8'h52, 8'h30, 8'h39, 8'h0A};
        expect_got("fb2b", e);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
